// File: rtl/serial_fs_sub_if.sv
// ---------------------------------------------------------------------------
// serial_fs_sub_if
// Handshake and data bundle for the bit-serial subtractor.
//   start     : operation request, sampled only while the subtractor is idle
//   a, b, bin : minuend, subtrahend and borrow-in, captured on accepted start
//   busy      : operation in progress (bit steps plus the done cycle)
//   done      : one-cycle completion pulse
//   diff      : a - b - bin modulo 2^N
//   bout      : unsigned borrow-out
//   ovf       : signed (two's-complement) overflow
//   zero      : diff == 0
// The master drives the request side; the slave (the subtractor) drives
// status and results.
// ---------------------------------------------------------------------------
interface serial_fs_sub_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf, zero
    );
endinterface

// File: rtl/serial_fs_sub.sv
// ---------------------------------------------------------------------------
// serial_fs_sub
// Bit-serial two's-complement subtractor: one full-subtractor cell and a
// borrow flip-flop compute diff = a - b - bin over N clocks, LSB first.
// Ports:
//   i_clk : rising-edge clock
//   i_rst : synchronous, active-high reset
//   bus   : serial_fs_sub_if.slave (start/a/b/bin in, busy/done/diff/bout/
//           ovf/zero out)
// Timing: start accepted in IDLE at edge 0, bits processed at edges 1..N,
// done high for the cycle after edge N, back in IDLE one edge later.
// Results hold until the next operation completes or reset.
// ---------------------------------------------------------------------------
module serial_fs_sub #(
    parameter int N = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    serial_fs_sub_if.slave bus
);
    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_a_sr;
    logic [N-1:0]  r_b_sr;
    logic [N-1:0]  r_res_sr;
    logic          r_br;
    logic [CW-1:0] r_cnt;
    logic          r_a_msb;
    logic          r_b_msb;
    logic          r_zacc;
    logic [N-1:0]  r_diff;
    logic          r_bout;
    logic          r_ovf;
    logic          r_zero;

    logic          w_ai;
    logic          w_bi;
    logic          w_d;
    logic          w_br_next;
    logic [N-1:0]  w_res_next;
    logic          w_last;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    assign w_ai       = r_a_sr[0];
    assign w_bi       = r_b_sr[0];
    assign w_d        = w_ai ^ w_bi ^ r_br;
    assign w_br_next  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    // Result bits enter at the MSB so that after N steps bit 0 holds the LSB.
    assign w_res_next = {w_d, r_res_sr[N-1:1]};
    assign w_last     = (r_cnt == CW'(N - 1));

    always_ff @(posedge i_clk) begin
        // NOTE: every register here uses non-blocking assignment so all of
        // them update from the same pre-edge values; reset is synchronous,
        // so it lives inside this edge-triggered block rather than in the
        // sensitivity list.
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_zacc   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.b;
                        r_br    <= bus.bin;
                        r_a_msb <= bus.a[N-1];
                        r_b_msb <= bus.b[N-1];
                        r_cnt   <= '0;
                        r_zacc  <= 1'b0;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_next;
                    r_br     <= w_br_next;
                    r_zacc   <= r_zacc | w_d;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        // Publish all result flags together with the final bit.
                        r_diff  <= w_res_next;
                        r_bout  <= w_br_next;
                        // Overflow only possible when operand signs differ and
                        // the result sign does not follow the minuend.
                        r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                        r_zero  <= ~(r_zacc | w_d);
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;

endmodule

// File: tb/tb_serial_fs_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_fs_sub
// Self-checking bench for serial_fs_sub (N = 8). A cycle-level reference
// computes results with plain arithmetic at the moment an operation is
// accepted and releases them N cycles later; a compare process checks every
// output on every falling edge. Directed vectors add literal expectations.
// ---------------------------------------------------------------------------
module tb_serial_fs_sub;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   n_done;
    bit   chk_en;

    serial_fs_sub_if #(.N(N)) bus ();

    serial_fs_sub #(.N(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Reference result: {ovf, zero, bout, diff}
    function automatic logic [N+2:0] ref_sub(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic bin);
        logic [N:0]   full;
        longint       sa;
        longint       sb;
        longint       sd;
        logic         ov;
        full = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
        sa   = $signed(a);
        sb   = $signed(b);
        sd   = sa - sb - longint'(bin);
        ov   = (sd > (longint'(1) <<< (N - 1)) - 1) || (sd < -(longint'(1) <<< (N - 1)));
        return {ov, (full[N-1:0] == '0), full[N], full[N-1:0]};
    endfunction

    // Cycle-level reference: m_t counts edges since acceptance.
    bit           m_busy;
    int           m_t;
    logic [N+2:0] m_pend;
    logic [N+2:0] m_out;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy <= 1'b0;
            m_t    <= 0;
            m_out  <= '0;
        end else if (!m_busy) begin
            if (bus.start) begin
                m_busy <= 1'b1;
                m_t    <= 0;
                m_pend <= ref_sub(bus.a, bus.b, bus.bin);
            end
        end else begin
            m_t <= m_t + 1;
            if (m_t + 1 == N)     m_out  <= m_pend;
            if (m_t + 1 == N + 1) m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_busy", 32'(bus.busy), 32'(m_busy));
            check("cmp_done", 32'(bus.done), 32'(m_busy && (m_t == N)));
            check("cmp_diff", 32'(bus.diff), 32'(m_out[N-1:0]));
            check("cmp_bout", 32'(bus.bout), 32'(m_out[N]));
            check("cmp_zero", 32'(bus.zero), 32'(m_out[N+1]));
            check("cmp_ovf",  32'(bus.ovf),  32'(m_out[N+2]));
            if (bus.done) n_done++;
        end
    end

    // One operation with literal expectations; returns at the cycle after done.
    task automatic run_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic bin, input logic [N-1:0] e_diff, input logic e_bout,
                          input logic e_ovf, input logic e_zero);
        int lat;
        int busy_cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.bin   = ~bin;
        lat      = 0;
        busy_cyc = bus.busy ? 1 : 0;
        while (!bus.done && lat < 4 * N) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_cyc++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(N));
        check({nm, "_busy_cycles"}, 32'(busy_cyc), 32'(N + 1));
        check({nm, "_diff"}, 32'(bus.diff), 32'(e_diff));
        check({nm, "_bout"}, 32'(bus.bout), 32'(e_bout));
        check({nm, "_ovf"},  32'(bus.ovf),  32'(e_ovf));
        check({nm, "_zero"}, 32'(bus.zero), 32'(e_zero));
        @(negedge clk);
        check({nm, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({nm, "_idle_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int d0;
        int last_done;
        logic [N-1:0] sa;
        logic [N-1:0] sb;
        logic         sbin;
        logic [N+2:0] e;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        n_done   = 0;
        chk_en   = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_diff", 32'(bus.diff), 32'd0);
        check("reset_flags", {29'd0, bus.bout, bus.ovf, bus.zero}, 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Directed vectors, hand-computed.
        run_op("sub_100_37",  8'd100, 8'd37,  1'b0, 8'd63,  1'b0, 1'b0, 1'b0);
        run_op("sub_0_1",     8'h00,  8'h01,  1'b0, 8'hFF,  1'b1, 1'b0, 1'b0);
        run_op("sub_80_1",    8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1, 1'b0);
        run_op("sub_55_55",   8'h55,  8'h55,  1'b0, 8'h00,  1'b0, 1'b0, 1'b1);
        run_op("sub_10_0f_b", 8'h10,  8'h0F,  1'b1, 8'h00,  1'b0, 1'b0, 1'b1);
        run_op("sub_20_20_b", 8'h20,  8'h20,  1'b1, 8'hFF,  1'b1, 1'b0, 1'b0);

        // Start re-pulsed during SHIFT and during DONE must be ignored.
        d0 = n_done;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd50; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        w = 0;
        while (!bus.done && w < 4 * N) begin @(negedge clk); w++; end
        check("ign_done_seen", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_idle_after_done", 32'(bus.busy), 32'd0);
        repeat (2 * N) @(negedge clk);
        check("ign_done_count", 32'(n_done - d0), 32'd1);
        check("ign_diff", 32'(bus.diff), 32'd150);
        check("ign_bout", 32'(bus.bout), 32'd0);

        // Reset sampled at the 4th SHIFT edge aborts the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'd37; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_diff", 32'(bus.diff), 32'd0);
        d0 = n_done;
        repeat (N + 4) @(negedge clk);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        run_op("sub_9_3", 8'd9, 8'd3, 1'b0, 8'd6, 1'b0, 1'b0, 1'b0);

        // Start held high: back-to-back operations every N+2 cycles.
        @(negedge clk);
        sa = N'($urandom); sb = N'($urandom); sbin = 1'($urandom);
        bus.a = sa; bus.b = sb; bus.bin = sbin;
        bus.start = 1'b1;
        last_done = 0;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (!bus.done && w < 4 * N) begin @(negedge clk); w++; end
            check("cont_done_seen", 32'(bus.done), 32'd1);
            e = ref_sub(sa, sb, sbin);
            check("cont_diff", 32'(bus.diff), 32'(e[N-1:0]));
            check("cont_bout", 32'(bus.bout), 32'(e[N]));
            check("cont_ovf",  32'(bus.ovf),  32'(e[N+2]));
            if (k > 0) check("cont_period", 32'(cyc - last_done), 32'(N + 2));
            last_done = cyc;
            sa = N'($urandom); sb = N'($urandom); sbin = 1'($urandom);
            bus.a = sa; bus.b = sb; bus.bin = sbin;
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (N + 4) @(negedge clk);
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
